// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Main control FSM of a multicycle CPU. It steps each instruction through
// fetch, decode, execute, memory and writeback, and drives the PC, IR,
// register-file, memory and ALU select lines. The branch qualifiers go to the
// external PC-write condition logic, which ORs pc_write with
//   (zero & isBEQ) | (!zero & isBNE) | (!gt & isBLE) | (gt & isBGT).
//
// Parameters
//   MEM_LAT      number of cycles a memory access is held (>= 1)
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high
//   opcode       IR[31:26]
//   funct        IR[5:0] (decoded by the ALU control, not by this FSM)
//   overflow     ALU signed overflow, looked at in EXEC_R / EXEC_I
//   pc_write     unconditional PC load
//   isBEQ/isBNE/isBGT/isBLE  branch qualifiers, one-hot or all zero
//   pc_src       0 ALU result, 1 ALUOut, 2 jump target, 3 exception vector
//   ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
//   alu_src_a    single-bit datapath controls
//   alu_src_b    0 B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm << 2
//   alu_op       0 add, 1 sub, 2 funct-decoded, 3 slt
//   state        current state code (debug)
//   epc_write, cause_write, cause   exception strobes (CTRL_EXCEPTION_EN only)
//
// Configuration
//   CTRL_EXCEPTION_EN  when defined, an illegal opcode or an arithmetic
//                      overflow goes through the EXCEPT state; when not
//                      defined, illegal opcodes return to FETCH with no side
//                      effects and overflow is ignored.
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    output logic       pc_write,
    output logic       isBEQ,
    output logic       isBNE,
    output logic       isBGT,
    output logic       isBLE,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [3:0] state
`ifdef CTRL_EXCEPTION_EN
    ,
    output logic       epc_write,
    output logic       cause_write,
    output logic       cause
`endif
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLE   = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_LD    = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_EXCEPT   = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       is_beq;
        logic       is_bne;
        logic       is_bgt;
        logic       is_ble;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;

`ifdef CTRL_EXCEPTION_EN
    logic epc_write_q, epc_write_d;
    logic cause_write_q, cause_write_d;
    logic cause_q, cause_d;
`endif

    // funct is decoded by the ALU control block; it is carried here only so
    // the port set matches the IR fields.
    logic unused_inputs;
`ifdef CTRL_EXCEPTION_EN
    assign unused_inputs = ^funct;
`else
    assign unused_inputs = ^{funct, overflow};
`endif

    // ------------------------------------------------------------------
    // Next state and wait counter. The counter is zero on entry to every
    // held state and counts up to MEM_LAT-1, where the state is left; it
    // therefore never wraps.
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (cnt_q == CNT_LAST) state_d = S_DECODE;
                else                   cnt_d   = cnt_q + CNT_ONE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                        state_d = S_EXEC_R;
                    OP_ADDI:                         state_d = S_EXEC_I;
                    OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BLE, OP_BGT:  state_d = S_BRANCH;
                    OP_J:                            state_d = S_JUMP;
`ifdef CTRL_EXCEPTION_EN
                    default:                         state_d = S_EXCEPT;
`else
                    default:                         state_d = S_FETCH;
`endif
                endcase
            end
`ifdef CTRL_EXCEPTION_EN
            S_EXEC_R: state_d = overflow ? S_EXCEPT : S_WB_R;
            S_EXEC_I: state_d = overflow ? S_EXCEPT : S_WB_I;
            S_EXCEPT: state_d = S_FETCH;
`else
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
`endif
            S_WB_R, S_WB_I, S_WB_LD, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (cnt_q == CNT_LAST) state_d = S_WB_LD;
                else                   cnt_d   = cnt_q + CNT_ONE;
            end
            S_MEM_WR: begin
                if (cnt_q == CNT_LAST) state_d = S_FETCH;
                else                   cnt_d   = cnt_q + CNT_ONE;
            end
            // Unused codes, and EXCEPT when exceptions are compiled out.
            default: state_d = S_RESET;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Outputs are the Moore decode of (state, counter), but
    // computed from the *next* state so they can be registered and still
    // line up with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d = '0;
`ifdef CTRL_EXCEPTION_EN
        epc_write_d   = 1'b0;
        cause_write_d = 1'b0;
        cause_d       = 1'b0;
`endif
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_read = 1'b1;
                if (cnt_d == CNT_LAST) begin
                    ctrl_d.ir_write  = 1'b1;
                    ctrl_d.pc_write  = 1'b1;
                    ctrl_d.alu_src_b = 2'd1;
                end
            end
            S_DECODE: ctrl_d.alu_src_b = 2'd3;
            S_EXEC_R: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 3'd2;
            end
            S_WB_R: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'd2;
            end
            S_WB_I: ctrl_d.reg_write = 1'b1;
            S_MEM_RD: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.iord     = 1'b1;
            end
            S_WB_LD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.iord      = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 3'd1;
                ctrl_d.pc_src    = 2'd1;
                // IR is stable from DECODE onward, so the opcode seen on the
                // DECODE->BRANCH transition is the branch's opcode.
                ctrl_d.is_beq    = (opcode == OP_BEQ);
                ctrl_d.is_bne    = (opcode == OP_BNE);
                ctrl_d.is_ble    = (opcode == OP_BLE);
                ctrl_d.is_bgt    = (opcode == OP_BGT);
            end
            S_JUMP: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = 2'd2;
            end
`ifdef CTRL_EXCEPTION_EN
            S_EXCEPT: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = 2'd3;
                epc_write_d     = 1'b1;
                cause_write_d   = 1'b1;
                // Entered from an execute state only on overflow; from
                // DECODE only on an illegal opcode.
                cause_d         = (state_q == S_EXEC_R) || (state_q == S_EXEC_I);
            end
`endif
            default: ctrl_d = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            ctrl_q  <= '0;
`ifdef CTRL_EXCEPTION_EN
            epc_write_q   <= 1'b0;
            cause_write_q <= 1'b0;
            cause_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
`ifdef CTRL_EXCEPTION_EN
            epc_write_q   <= epc_write_d;
            cause_write_q <= cause_write_d;
            cause_q       <= cause_d;
`endif
        end
    end

    assign state      = state_q;
    assign pc_write   = ctrl_q.pc_write;
    assign isBEQ      = ctrl_q.is_beq;
    assign isBNE      = ctrl_q.is_bne;
    assign isBGT      = ctrl_q.is_bgt;
    assign isBLE      = ctrl_q.is_ble;
    assign pc_src     = ctrl_q.pc_src;
    assign ir_write   = ctrl_q.ir_write;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign iord       = ctrl_q.iord;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
`ifdef CTRL_EXCEPTION_EN
    assign epc_write   = epc_write_q;
    assign cause_write = cause_write_q;
    assign cause       = cause_q;
`endif

endmodule
